iic_bus_frontend: RTL and testbench

- Upstream pad-side stage of the IIC slave controller.
- Synchronises and glitch-filters raw SCL/SDA pad inputs, then generates the controller's SCL, SDA_recv, edge_scl, start and stop inputs.
- Tracks bus busy/free and converts the controller's grab_SDA/SDA_drive into an open-drain pad enable.
- Sits between the IO pads and the controller.

---
 rtl/iic_pkg.sv | 13 +
 rtl/iic_line_filter.sv | 62 ++++++
 rtl/iic_bus_frontend.sv | 111 +++++++++++
 tb/tb_iic_bus_frontend.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared constants and types for the IIC slave front end and controller.
package iic_pkg;

  localparam logic [6:0] ADDRESS         = 7'd69;
  localparam int         DEF_SYNC_STAGES = 2;
  localparam int         DEF_FILTER_LEN  = 3;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } bus_state_t;

endpackage

// File: rtl/iic_line_filter.sv
// One pad line: reset-to-1 synchroniser followed by a stable-count glitch filter.
module iic_line_filter
  import iic_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic change,
  output logic rise,
  output logic fall
);

  localparam int              CW       = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
    end
  end

  // The pulses are registered alongside level so they coincide with the new value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level  <= 1'b1;
      cnt    <= '0;
      change <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      change <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      if (synced != level) begin
        if (cnt == CNT_LAST) begin
          level  <= synced;
          cnt    <= '0;
          change <= 1'b1;
          rise   <= synced;
          fall   <= ~synced;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/iic_bus_frontend.sv
// Pad-side stage of the IIC slave: filtered lines, START/STOP detection,
// bus busy tracking and open-drain SDA enable.
module iic_bus_frontend
  import iic_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int BUS_TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_pad,
  input  logic sda_pad,
  input  logic grab_SDA,
  input  logic SDA_drive,
  output logic SCL,
  output logic SDA_recv,
  output logic edge_scl,
  output logic start,
  output logic stop,
  output logic bus_busy,
  output logic sda_oe
);

  localparam int ARM_LEN = SYNC_STAGES + FILTER_LEN;
  localparam int AW      = $clog2(ARM_LEN + 1);
  localparam int TW      = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;

  logic          scl_change, unused_scl_rise, unused_scl_fall;
  logic          unused_sda_change, sda_rise, sda_fall;
  logic [AW-1:0] arm_cnt;
  logic          armed;
  logic          scl_quiet;
  logic [TW-1:0] to_cnt;
  logic          idle_lines;
  logic          timeout_hit;
  bus_state_t    state;

  iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk    (clk),
    .reset  (reset),
    .pad    (scl_pad),
    .level  (SCL),
    .change (scl_change),
    .rise   (unused_scl_rise),
    .fall   (unused_scl_fall)
  );

  iic_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk    (clk),
    .reset  (reset),
    .pad    (sda_pad),
    .level  (SDA_recv),
    .change (unused_sda_change),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  // armed rises one cycle after the counter completes, so a filtered change
  // landing on the final arm cycle (pads low at reset release) is still masked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == AW'(ARM_LEN)) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 1'b1;
      end
    end
  end

  // An SDA edge only counts as START/STOP when SCL is high and not moving.
  assign scl_quiet = armed & SCL & ~scl_change;
  assign edge_scl  = armed & scl_change;
  assign start     = scl_quiet & sda_fall;
  assign stop      = scl_quiet & sda_rise;
  assign bus_busy  = (state == BUSY);

  assign idle_lines  = SCL & SDA_recv;
  assign timeout_hit = (BUS_TIMEOUT > 0) && (state == BUSY) && idle_lines
                       && ((int'(to_cnt) + 1) == BUS_TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FREE;
      to_cnt <= '0;
    end else begin
      if ((state == BUSY) && idle_lines && !timeout_hit) begin
        to_cnt <= to_cnt + 1'b1;
      end else begin
        to_cnt <= '0;
      end
      case (state)
        FREE:    if (start) state <= BUSY;
        BUSY:    if (stop || timeout_hit) state <= FREE;
        default: state <= FREE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_oe <= 1'b0;
    end else begin
      sda_oe <= armed & grab_SDA & ~SDA_drive;
    end
  end

endmodule

// File: tb/tb_iic_bus_frontend.sv
// Directed bench for iic_bus_frontend at default parameters.
module tb_iic_bus_frontend;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_pad = 1'b1;
  logic sda_pad = 1'b1;
  logic grab_SDA = 1'b0;
  logic SDA_drive = 1'b0;
  logic SCL, SDA_recv, edge_scl, start, stop, bus_busy, sda_oe;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0, rise_cnt = 0, fall_cnt = 0, start_cnt = 0, stop_cnt = 0, scl_low_cnt = 0;
  int s_edge, s_rise, s_fall, s_start, s_stop;
  logic [8:0] frame;

  iic_bus_frontend dut (
    .clk       (clk),
    .reset     (reset),
    .scl_pad   (scl_pad),
    .sda_pad   (sda_pad),
    .grab_SDA  (grab_SDA),
    .SDA_drive (SDA_drive),
    .SCL       (SCL),
    .SDA_recv  (SDA_recv),
    .edge_scl  (edge_scl),
    .start     (start),
    .stop      (stop),
    .bus_busy  (bus_busy),
    .sda_oe    (sda_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (edge_scl) edge_cnt++;
      if (edge_scl && SCL) rise_cnt++;
      if (edge_scl && !SCL) fall_cnt++;
      if (start) start_cnt++;
      if (stop) stop_cnt++;
      if (!SCL) scl_low_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_edge  = edge_cnt;
    s_rise  = rise_cnt;
    s_fall  = fall_cnt;
    s_start = start_cnt;
    s_stop  = stop_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", 32'(SCL), 1);
    check("rst_sda", 32'(SDA_recv), 1);
    check("rst_edge", 32'(edge_scl), 0);
    check("rst_start", 32'(start), 0);
    check("rst_stop", 32'(stop), 0);
    check("rst_busy", 32'(bus_busy), 0);
    check("rst_oe", 32'(sda_oe), 0);
    reset = 1'b0;

    // START at cycle 10: SDA_recv falls after edge 15, busy after edge 16
    tick(10);
    sda_pad = 1'b0;
    tick(4);
    check("start_sda_before", 32'(SDA_recv), 1);
    tick(1);
    check("start_sda_fell", 32'(SDA_recv), 0);
    check("start_pulse", 32'(start), 1);
    check("start_busy_lag", 32'(bus_busy), 0);
    tick(1);
    check("start_pulse_end", 32'(start), 0);
    check("start_busy", 32'(bus_busy), 1);
    check("start_no_edges", 32'(edge_cnt), 0);

    // 2-cycle glitch is rejected, 3-cycle pulse passes
    snap();
    scl_pad = 1'b0;
    tick(2);
    scl_pad = 1'b1;
    tick(10);
    check("glitch2_edges", 32'(edge_cnt - s_edge), 0);
    check("glitch2_low", 32'(scl_low_cnt), 0);
    scl_pad = 1'b0;
    tick(3);
    scl_pad = 1'b1;
    tick(10);
    check("pulse3_edges", 32'(edge_cnt - s_edge), 2);
    check("pulse3_low", 32'(scl_low_cnt), 3);
    check("pulse3_scl", 32'(SCL), 1);
    check("pulse3_busy", 32'(bus_busy), 1);

    // Address 0x45 + W, then ACK, at 20-cycle SCL period
    snap();
    frame = {8'h8A, 1'b0};
    for (int i = 8; i >= 0; i--) begin
      scl_pad = 1'b0;
      tick(5);
      sda_pad = frame[i];
      tick(5);
      scl_pad = 1'b1;
      tick(10);
    end
    check("frame_edges", 32'(edge_cnt - s_edge), 18);
    check("frame_rises", 32'(rise_cnt - s_rise), 9);
    check("frame_falls", 32'(fall_cnt - s_fall), 9);
    check("frame_starts", 32'(start_cnt - s_start), 0);
    check("frame_stops", 32'(stop_cnt - s_stop), 0);
    check("frame_busy", 32'(bus_busy), 1);

    // Repeated START, then STOP
    scl_pad = 1'b0;
    tick(5);
    sda_pad = 1'b1;
    tick(5);
    scl_pad = 1'b1;
    tick(10);
    sda_pad = 1'b0;
    tick(10);
    check("rstart_count", 32'(start_cnt), 2);
    check("rstart_busy", 32'(bus_busy), 1);
    sda_pad = 1'b1;
    tick(5);
    check("stop_pulse", 32'(stop), 1);
    check("stop_busy_lag", 32'(bus_busy), 1);
    tick(1);
    check("stop_pulse_end", 32'(stop), 0);
    check("stop_free", 32'(bus_busy), 0);
    check("stop_count", 32'(stop_cnt), 1);

    // Simultaneous SCL/SDA change: edge only; then STOP while FREE
    snap();
    scl_pad = 1'b0;
    sda_pad = 1'b0;
    tick(10);
    check("simul_edges", 32'(edge_cnt - s_edge), 1);
    check("simul_starts", 32'(start_cnt - s_start), 0);
    check("simul_busy", 32'(bus_busy), 0);
    scl_pad = 1'b1;
    tick(10);
    check("simul_rise_edges", 32'(edge_cnt - s_edge), 2);
    sda_pad = 1'b1;
    tick(10);
    check("free_stop_pulse", 32'(stop_cnt - s_stop), 1);
    check("free_stop_busy", 32'(bus_busy), 0);

    // sda_oe follows grab_SDA & ~SDA_drive one cycle later
    grab_SDA  = 1'b1;
    SDA_drive = 1'b0;
    check("oe_not_yet", 32'(sda_oe), 0);
    tick(1);
    check("oe_on", 32'(sda_oe), 1);
    SDA_drive = 1'b1;
    tick(1);
    check("oe_off", 32'(sda_oe), 0);
    SDA_drive = 1'b0;
    tick(1);
    check("oe_on_again", 32'(sda_oe), 1);

    // Asynchronous reset in the middle of a transfer
    sda_pad = 1'b0;
    tick(6);
    check("mid_busy", 32'(bus_busy), 1);
    reset = 1'b1;
    #1;
    check("arst_oe", 32'(sda_oe), 0);
    check("arst_busy", 32'(bus_busy), 0);
    check("arst_scl", 32'(SCL), 1);
    check("arst_sda", 32'(SDA_recv), 1);
    check("arst_stop", 32'(stop), 0);

    // Pads held low through reset release
    scl_pad = 1'b0;
    tick(2);
    snap();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("arm_scl_high", 32'(SCL), 1);
      check("arm_oe", 32'(sda_oe), 0);
    end
    tick(1);
    check("arm_scl_fell", 32'(SCL), 0);
    check("arm_sda_fell", 32'(SDA_recv), 0);
    check("arm_edge_masked", 32'(edge_scl), 0);
    check("arm_start_masked", 32'(start), 0);
    check("arm_oe_5", 32'(sda_oe), 0);
    tick(1);
    check("arm_oe_6", 32'(sda_oe), 0);
    tick(1);
    check("armed_oe", 32'(sda_oe), 1);
    tick(5);
    check("arm_edges", 32'(edge_cnt - s_edge), 0);
    check("arm_starts", 32'(start_cnt - s_start), 0);
    check("arm_stops", 32'(stop_cnt - s_stop), 0);
    check("arm_busy", 32'(bus_busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
